div_seq: RTL and testbench
==========================

# div_seq

Parametrised sequential integer divider for the datapath's multi-cycle arithmetic unit. It accepts one signed or unsigned divide per transaction over a valid/ready handshake and runs radix-2 restoring iterations, one quotient bit per cycle. It returns a truncating (round-toward-zero) quotient and remainder, with dedicated divide-by-zero and signed-overflow flags. Output backpressure is supported, and results are held until consumed.

## Interface
- DIVIDEND_WIDTH, 64, dividend and quotient width W; must be ≥ DIVISOR_WIDTH and ≥ 2
- DIVISOR_WIDTH, 32, divisor and remainder width D; must be ≥ 2
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- dividend  in  W  numerator
- divisor  in  D  denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  W  quotient
- remainder  out  D  remainder
- div_by_zero  out  1  divisor was zero
- overflow  out  1  signed most-negative / −1

## Operation
- **States:** IDLE, PREP, LOOP, FIX, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch dividend, divisor and signed_mode, then go to PREP.
- **PREP:**
  - Compute |dividend| (W-bit unsigned) and |divisor| (D-bit unsigned).
  - In unsigned mode, abs is the identity.
  - Record sign_q = dividend MSB ^ divisor MSB, and sign_r = dividend MSB (both forced to 0 in unsigned mode).
  - If divisor == 0: quotient = all ones, remainder = dividend[D-1:0], div_by_zero = 1; go to DONE.
  - Else if signed_mode and dividend == 1 followed by W−1 zeros and divisor == all ones: quotient = dividend, remainder = 0, overflow = 1; go to DONE.
  - Else clear the partial remainder (D+1 bits) and the quotient; go to LOOP.
- **LOOP:** restoring iteration, MSB first.
  - Shift the next dividend bit into the partial remainder.
  - If partial remainder ≥ |divisor|: subtract, and shift a 1 into the quotient; otherwise shift a 0.
  - Iteration counter runs from W down to 0; go to FIX after the last iteration.
- **FIX:**
  - quotient = sign_q ? −q : q.
  - remainder = sign_r ? −r : r.
  - Flags = 0. Go to DONE.
- **DONE:**
  - out_valid = 1; result registers are stable.
  - On out_ready: go to IDLE.
- **Result invariants:**
  - dividend == quotient·divisor + remainder (mod 2^W).
  - |remainder| < |divisor|.
  - A nonzero remainder has the sign of the dividend.
- **Unsigned all-ones divisor:** an ordinary divide, not a special case.

## Timing
- Request accepted at edge T:
  - PREP in cycle T+1.
  - Normal divide: LOOP from T+2 to T+W+1, FIX at T+W+2, out_valid from T+W+3. Latency is W+3 cycles; for W=64 that is 67.
  - Zero-divisor or overflow case: out_valid from T+2.
- **Throughput:** one divide in flight. in_ready = 0 from PREP until the cycle after the out_valid & out_ready handshake.
- **Output stability:** while out_valid & !out_ready, quotient, remainder and both flags are held stable.
- **Inputs:** dividend, divisor and signed_mode are sampled only at the accept edge; later input changes are ignored.
- **Reset values:** state = IDLE; out_valid = 0; quotient, remainder, div_by_zero, overflow = 0; in_ready = 1 once state is IDLE.
- **Reset mid-operation:** aborts immediately; no output is produced for the aborted request.

## Configuration
- DIV_EARLY_TERM_EN
  - **Defined:** PREP computes n = W − clz(|dividend|) and pre-shifts |dividend| left by clz, so LOOP runs only n iterations.
    - If n == 0 (dividend zero), PREP goes straight to FIX: out_valid at T+3, quotient 0, remainder 0.
    - Latency is n+3 cycles.
    - Results are bit-identical to the undefined case.
  - **Undefined:** fixed W iterations, fixed latency of W+3 cycles, no count-leading-zeros logic.

## Test plan
- **Unsigned 100/7** (W=64, D=32, signed_mode=0) -> quotient 14, remainder 2, flags 0; out_valid exactly 67 cycles after accept (macro undefined).
- **Signed −7/2** -> quotient −3 (0xFFFF_FFFF_FFFF_FFFD), remainder −1 (0xFFFF_FFFF); signed 7/−2 -> quotient −3, remainder 1.
- **Divide by zero,** 5/0 in both modes -> quotient all ones, remainder 5, div_by_zero 1; out_valid at T+2.
- **Signed overflow,** 0x8000_0000_0000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000_0000_0000, remainder 0, overflow 1; out_valid at T+2. Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0xFFFF_FFFF -> quotient 0x1_0000_0001, remainder 0.
- **Backpressure:** out_ready held low 10 cycles after out_valid -> outputs constant, in_ready 0, and a new in_valid is not accepted. Release -> IDLE the next cycle, and back-to-back requests then complete in order.
- **Reset:**
  - Reset asserted mid-LOOP -> out_valid 0 and all outputs 0 immediately; the next request completes normally.
  - With DIV_EARLY_TERM_EN defined, 100/7 completes in 10 cycles (n=7), and 0/3 in 3 cycles.

Source files
------------

// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle for the sequential divider.
//   Request  : in_valid, in_ready, signed_mode, dividend[W], divisor[D]
//   Response : out_valid, out_ready, quotient[W], remainder[D],
//              div_by_zero, overflow
// master = requester/consumer side, slave = the divider.
interface div_seq_if #(
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      signed_mode;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output in_valid, signed_mode, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, signed_mode, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring divider, one quotient bit per cycle, signed or
// unsigned, truncating quotient/remainder with divide-by-zero and signed
// overflow flags. One divide in flight; result held until consumed.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high reset
//   bus      div_seq_if.slave (request handshake, operands, result, flags)
//
// Optional macro DIV_EARLY_TERM_EN: skip the leading zeros of |dividend| so
// LOOP runs only as many iterations as |dividend| has significant bits.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// PREP  | take magnitudes, record signs, catch /0 and MIN/-1
// LOOP  | one restoring iteration per cycle
// FIX   | apply signs to quotient and remainder
// DONE  | result valid, wait for out_ready
module div_seq #(
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32
) (
  input logic      clk_i,
  input logic      reset_i,
  div_seq_if.slave bus
);
  localparam int W     = DIVIDEND_WIDTH;
  localparam int D     = DIVISOR_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_LOOP, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  // dvd_q holds the operand during PREP, then doubles as the shift register:
  // dividend bits leave at the top while quotient bits enter at the bottom.
  logic [W-1:0]     dvd_q;
  logic [D-1:0]     dvs_q;
  logic             smode_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [D-1:0]     prem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     quo_q;
  logic [D-1:0]     rem_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [W-1:0] abs_dvd;
  logic [D-1:0] abs_dvs;
  logic         dvs_zero;
  logic         ovf_case;
  logic [D:0]   prem_shift;
  logic         prem_ge;
  logic [D-1:0] prem_diff;

  assign abs_dvd  = (smode_q && dvd_q[W-1]) ? -dvd_q : dvd_q;
  assign abs_dvs  = (smode_q && dvs_q[D-1]) ? -dvs_q : dvs_q;
  assign dvs_zero = (dvs_q == '0);
  assign ovf_case = smode_q && (dvd_q == {1'b1, {(W-1){1'b0}}}) && (dvs_q == '1);

  // The partial remainder is always below the divisor, so after a restore it
  // fits in D bits; only the shifted value needs the extra top bit.
  assign prem_shift = {prem_q, dvd_q[W-1]};
  assign prem_ge    = (prem_shift >= {1'b0, dvs_q});
  assign prem_diff  = prem_shift[D-1:0] - dvs_q;

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] clz;
  logic [CNT_W-1:0] n_bits;

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    clz = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (abs_dvd[i]) clz = CNT_W'(W - 1 - i);
    end
  end

  assign n_bits = CNT_W'(W) - clz;
`endif

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_PREP;
      S_PREP: begin
        if (dvs_zero || ovf_case) state_d = S_DONE;
`ifdef DIV_EARLY_TERM_EN
        else if (n_bits == '0)    state_d = S_FIX;
`endif
        else                      state_d = S_LOOP;
      end
      S_LOOP: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

  // Datapath
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      smode_q  <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      prem_q   <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            smode_q <= bus.signed_mode;
          end
        end
        S_PREP: begin
          sign_q_q <= smode_q & (dvd_q[W-1] ^ dvs_q[D-1]);
          sign_r_q <= smode_q & dvd_q[W-1];
          prem_q   <= '0;
          dvs_q    <= abs_dvs;
          if (dvs_zero) begin
            quo_q <= '1;
            rem_q <= dvd_q[D-1:0];
            dbz_q <= 1'b1;
            ovf_q <= 1'b0;
          end else if (ovf_case) begin
            quo_q <= dvd_q;
            rem_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b1;
          end else begin
`ifdef DIV_EARLY_TERM_EN
            dvd_q <= abs_dvd << clz;
            cnt_q <= n_bits;
`else
            dvd_q <= abs_dvd;
            cnt_q <= CNT_W'(W);
`endif
          end
        end
        S_LOOP: begin
          prem_q <= prem_ge ? prem_diff : prem_shift[D-1:0];
          dvd_q  <= {dvd_q[W-2:0], prem_ge};
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          quo_q <= sign_q_q ? -dvd_q : dvd_q;
          rem_q <= sign_r_q ? -prem_q : prem_q;
          dbz_q <= 1'b0;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
  localparam int W = 64;
  localparam int D = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_seq_if #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(D)) bus ();

  div_seq #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(D)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sm;
    logic [W-1:0] a;
    logic [D-1:0] b;
    logic [W-1:0] q;
    logic [D-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat_full;
    int           lat_et;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Bounded wait for out_valid; cyc counts cycles with the PREP cycle as 1.
  task automatic wait_valid(input string name, inout int cyc);
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.out_valid) begin
      errors++;
      checks++;
      $display("FAIL %s: timeout, out_valid still %b after %0d cycles", name, bus.out_valid, cyc);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_div(input string name, input logic sm, input logic [W-1:0] a,
                         input logic [D-1:0] b, output logic [W-1:0] q,
                         output logic [D-1:0] r, output logic dbz, output logic ovf,
                         output int lat);
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.dividend    = ~a;
    bus.divisor     = 32'd3;
    bus.signed_mode = ~sm;
    lat = 1;
    wait_valid(name, lat);
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    ovf = bus.overflow;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [W-1:0] q;
  logic [D-1:0] r;
  logic         dbz;
  logic         ovf;
  int           lat;
  int           exp_lat;

  initial begin
    vecs[0]  = '{1'b0, 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 1'b0, 67, 10};
    vecs[1]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 67, 6};
    vecs[2]  = '{1'b1, 64'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 32'd1, 1'b0, 1'b0, 67, 6};
    vecs[3]  = '{1'b0, 64'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1'b1, 1'b0, 2, 2};
    vecs[4]  = '{1'b1, 64'd5, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 1'b1, 1'b0, 2, 2};
    vecs[5]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 2, 2};
    vecs[6]  = '{1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 32'd0, 1'b0, 1'b1, 2, 2};
    vecs[7]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 32'd0, 1'b0, 1'b0, 67, 67};
    vecs[8]  = '{1'b0, 64'd0, 32'd3, 64'd0, 32'd0, 1'b0, 1'b0, 67, 3};
    vecs[9]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 64'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 67, 10};
    vecs[10] = '{1'b1, 64'h8000_0000_0000_0000, 32'd2, 64'hC000_0000_0000_0000, 32'd0, 1'b0, 1'b0, 67, 67};
    vecs[11] = '{1'b0, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32'h8000_0000, 1'b0, 1'b0, 67, 67};
    vecs[12] = '{1'b1, 64'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0, 1'b0, 67, 4};

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset quotient", bus.quotient, 64'd0);
    check("reset remainder", 64'(bus.remainder), 64'd0);
    check("reset flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);

    for (int i = 0; i < NV; i++) begin
      run_div($sformatf("v%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, q, r, dbz, ovf, lat);
`ifdef DIV_EARLY_TERM_EN
      exp_lat = vecs[i].lat_et;
`else
      exp_lat = vecs[i].lat_full;
`endif
      check($sformatf("v%0d quotient", i), q, vecs[i].q);
      check($sformatf("v%0d remainder", i), 64'(r), 64'(vecs[i].r));
      check($sformatf("v%0d div_by_zero", i), 64'(dbz), 64'(vecs[i].dbz));
      check($sformatf("v%0d overflow", i), 64'(ovf), 64'(vecs[i].ovf));
      check($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat));
    end

    // Backpressure: hold the 100/7 result, offer a competing request meanwhile.
    bus.signed_mode = 1'b0;
    bus.dividend    = 64'd100;
    bus.divisor     = 32'd7;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    wait_valid("bp first", lat);
    bus.dividend = 64'd50;
    bus.divisor  = 32'd5;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp c%0d out_valid", c), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp c%0d in_ready", c), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp c%0d quotient", c), bus.quotient, 64'd14);
      check($sformatf("bp c%0d remainder", c), 64'(bus.remainder), 64'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release out_valid", 64'(bus.out_valid), 64'd0);
    check("bp release in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp second accepted", 64'(bus.in_ready), 64'd0);
    lat = 1;
    wait_valid("bp second", lat);
    check("bp second quotient", bus.quotient, 64'd10);
    check("bp second remainder", 64'(bus.remainder), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_div("bp third", 1'b0, 64'd9, 32'd4, q, r, dbz, ovf, lat);
    check("bp third quotient", q, 64'd2);
    check("bp third remainder", 64'(r), 64'd1);

    // Reset in the middle of LOOP.
    bus.signed_mode = 1'b0;
    bus.dividend    = 64'd1000;
    bus.divisor     = 32'd7;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-reset out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-reset quotient", bus.quotient, 64'd0);
    check("mid-reset remainder", 64'(bus.remainder), 64'd0);
    check("mid-reset flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    run_div("post-reset", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, q, r, dbz, ovf, lat);
    check("post-reset quotient", q, 64'hFFFF_FFFF_FFFF_FFF2);
    check("post-reset remainder", 64'(r), 64'h0000_0000_FFFF_FFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
